// File: rtl/motion_alarm_if.sv
// Sensor/switch inputs and alarm/LED outputs of the motion alarm controller.
// The master drives switches and sensors; the slave is the controller.
interface motion_alarm_if;
  logic       turn;
  logic       stop_alarm;
  logic       pir_sensor_1;
  logic       pir_sensor_2;
  logic       pir_sensor_3;
  logic       armed;
  logic       alarm;
  logic       led_blink;
  logic [2:0] zone;
  logic [7:0] alarm_count;

  modport master (
    output turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    input  armed, alarm, led_blink, zone, alarm_count
  );

  modport slave (
    input  turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    output armed, alarm, led_blink, zone, alarm_count
  );
endinterface

// File: rtl/motion_alarm_ctrl.sv
// Motion alarm controller: synchronises switch/sensor inputs, confirms persistent
// motion, holds the alarm for a minimum time and counts alarm entries.
module motion_alarm_ctrl #(
  parameter int CONFIRM_CYCLES   = 3,
  parameter int ALARM_MIN_CYCLES = 16,
  parameter int BLINK_DIV        = 4
) (
  input logic           clk,
  input logic           rst,
  motion_alarm_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CONFIRM = 2'd2;
  localparam logic [1:0] ALARM   = 2'd3;

  localparam logic [3:0] CONF_LAST = 4'(CONFIRM_CYCLES - 1);
  localparam logic [7:0] HOLD_MIN  = 8'(ALARM_MIN_CYCLES);
  localparam logic [7:0] DIV_LAST  = 8'(BLINK_DIV - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser, packed as {pir3, pir2, pir1, stop, turn}
  logic [4:0] sync_p0, sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1,
                  bus.stop_alarm, bus.turn};
      sync_p1 <= sync_p0;
    end
  end

  logic       turn_s, stop_s, motion;
  logic [2:0] pir_s;

  assign turn_s = sync_p1[0];
  assign stop_s = sync_p1[1];
  assign pir_s  = sync_p1[4:2];
  assign motion = |pir_s;

  logic [1:0] state, state_nx;
  logic [3:0] conf_cnt, conf_nx;
  logic [7:0] hold_cnt, hold_nx, div_cnt, div_nx, count_q, count_nx;
  logic [2:0] zone_q, zone_nx;
  logic       blink_q, blink_nx, armed_q, alarm_q, enter;

  always_comb begin
    state_nx = state;
    conf_nx  = conf_cnt;
    hold_nx  = hold_cnt;
    div_nx   = div_cnt;
    zone_nx  = zone_q;
    count_nx = count_q;
    blink_nx = blink_q;
    enter    = 1'b0;
    if (!turn_s) begin
      state_nx = IDLE;
      conf_nx  = '0;
      hold_nx  = '0;
      div_nx   = '0;
      zone_nx  = '0;
      blink_nx = 1'b0;
    end else begin
      case (state)
        IDLE: state_nx = ARMED;
        ARMED: begin
          if (motion) begin
            zone_nx = zone_q | pir_s;
            if (CONFIRM_CYCLES == 1) begin
              enter = 1'b1;
            end else begin
              state_nx = CONFIRM;
              conf_nx  = 4'd1;
            end
          end
        end
        CONFIRM: begin
          if (motion) begin
            zone_nx = zone_q | pir_s;
            if (conf_cnt == CONF_LAST) enter = 1'b1;
            else conf_nx = conf_cnt + 4'd1;
          end else begin
            state_nx = ARMED;
            zone_nx  = '0;
            conf_nx  = '0;
          end
        end
        ALARM: begin
          // A stop seen before the minimum hold is simply dropped
          if (stop_s && hold_cnt == HOLD_MIN) begin
            state_nx = ARMED;
            zone_nx  = '0;
            hold_nx  = '0;
            div_nx   = '0;
            blink_nx = 1'b0;
          end else begin
            zone_nx = zone_q | pir_s;
            hold_nx = sat_inc(hold_cnt, HOLD_MIN);
            if (div_cnt == DIV_LAST) begin
              div_nx   = '0;
              blink_nx = ~blink_q;
            end else begin
              div_nx = div_cnt + 8'd1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    if (enter) begin
      state_nx = ALARM;
      conf_nx  = '0;
      hold_nx  = '0;
      div_nx   = '0;
      blink_nx = 1'b1;
      count_nx = sat_inc(count_q, 8'd255);
    end
  end

  // Stage p2: state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      conf_cnt <= '0;
      hold_cnt <= '0;
      div_cnt  <= '0;
      zone_q   <= '0;
      count_q  <= '0;
      blink_q  <= 1'b0;
      armed_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      conf_cnt <= conf_nx;
      hold_cnt <= hold_nx;
      div_cnt  <= div_nx;
      zone_q   <= zone_nx;
      count_q  <= count_nx;
      blink_q  <= blink_nx;
      armed_q  <= (state_nx != IDLE);
      alarm_q  <= (state_nx == ALARM);
    end
  end

  assign bus.armed       = armed_q;
  assign bus.alarm       = alarm_q;
  assign bus.led_blink   = blink_q;
  assign bus.zone        = zone_q;
  assign bus.alarm_count = count_q;
endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// Bench for motion_alarm_ctrl: vector table, corner-case sequences and random
// stimulus against a cycle-level behavioural model.
module tb_motion_alarm_ctrl;
  localparam int CONFIRM_CYCLES   = 3;
  localparam int ALARM_MIN_CYCLES = 16;
  localparam int BLINK_DIV        = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  motion_alarm_if bus ();

  motion_alarm_ctrl #(
    .CONFIRM_CYCLES  (CONFIRM_CYCLES),
    .ALARM_MIN_CYCLES(ALARM_MIN_CYCLES),
    .BLINK_DIV       (BLINK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model: inputs arrive two edges late; motion must run for
  // CONFIRM_CYCLES synced cycles; blink phase derives from time in alarm.
  logic [4:0] m_d1, m_d2;
  bit         m_armed, m_alarm;
  int         m_run, m_t;
  logic [2:0] m_zone;
  int         m_count;

  function automatic void model_reset();
    m_d1 = '0; m_d2 = '0; m_armed = 0; m_alarm = 0;
    m_run = 0; m_t = 0; m_zone = '0; m_count = 0;
  endfunction

  function automatic void model_edge(input logic [4:0] s);
    logic       turn, stop;
    logic [2:0] pir;
    turn = s[0]; stop = s[1]; pir = s[4:2];
    if (!turn) begin
      m_armed = 0; m_alarm = 0; m_run = 0; m_t = 0; m_zone = '0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (m_alarm) begin
      m_zone = m_zone | pir;
      if (stop && m_t >= ALARM_MIN_CYCLES) begin
        m_alarm = 0; m_zone = '0; m_run = 0; m_t = 0;
      end else begin
        m_t++;
      end
    end else if (pir != 3'b000) begin
      m_run++;
      m_zone = m_zone | pir;
      if (m_run >= CONFIRM_CYCLES) begin
        m_alarm = 1; m_t = 0; m_run = 0;
        if (m_count < 255) m_count++;
      end
    end else begin
      m_run = 0; m_zone = '0;
    end
  endfunction

  function automatic logic [13:0] model_pack();
    logic blink;
    blink = m_alarm && (((m_t / BLINK_DIV) % 2) == 0);
    return {m_armed, m_alarm, blink, m_zone, 8'(m_count)};
  endfunction

  function automatic logic [13:0] dut_pack();
    return {bus.armed, bus.alarm, bus.led_blink, bus.zone, bus.alarm_count};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (armed,alarm,blink,zone,count)", name, act, exp);
    end
  endtask

  task automatic drive(input logic turn, input logic stop, input logic [2:0] pir);
    bus.turn         = turn;
    bus.stop_alarm   = stop;
    bus.pir_sensor_1 = pir[0];
    bus.pir_sensor_2 = pir[1];
    bus.pir_sensor_3 = pir[2];
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_edge(m_d2);
      m_d2 = m_d1;
      m_d1 = {bus.pir_sensor_3, bus.pir_sensor_2, bus.pir_sensor_1,
              bus.stop_alarm, bus.turn};
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
  endtask

  // sel 0 waits on alarm, sel 1 on armed
  task automatic wait_out(input string name, input int sel, input logic val, input int budget);
    logic cur;
    for (int k = 0; k < budget; k++) begin
      cur = (sel == 0) ? bus.alarm : bus.armed;
      if (cur == val) break;
      step();
    end
    cur = (sel == 0) ? bus.alarm : bus.armed;
    check(name, {13'd0, cur}, {13'd0, val});
  endtask

  typedef struct {
    logic       turn;
    logic       stop;
    logic [2:0] pir;
    int         edges;
    logic       armed;
    logic       alarm;
    logic       blink;
    logic [2:0] zone;
    logic [7:0] count;
  } vec_t;

  function automatic vec_t v(input logic turn, input logic stop, input logic [2:0] pir,
                             input int edges, input logic armed, input logic alarm,
                             input logic blink, input logic [2:0] zone, input logic [7:0] count);
    vec_t r;
    r.turn = turn; r.stop = stop; r.pir = pir; r.edges = edges;
    r.armed = armed; r.alarm = alarm; r.blink = blink; r.zone = zone; r.count = count;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    //            turn stop pir   n  arm alm blk zone    count
    tbl.push_back(v(1, 0, 3'b000, 2,  0, 0, 0, 3'b000, 8'd0));
    tbl.push_back(v(1, 0, 3'b000, 1,  1, 0, 0, 3'b000, 8'd0));
    tbl.push_back(v(1, 0, 3'b000, 17, 1, 0, 0, 3'b000, 8'd0));
    tbl.push_back(v(1, 0, 3'b101, 4,  1, 0, 0, 3'b101, 8'd0));
    tbl.push_back(v(1, 0, 3'b101, 1,  1, 1, 1, 3'b101, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 3,  1, 1, 1, 3'b101, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 1,  1, 1, 0, 3'b101, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 4,  1, 1, 1, 3'b101, 8'd1));
    tbl.push_back(v(1, 1, 3'b000, 8,  1, 1, 1, 3'b101, 8'd1));
    tbl.push_back(v(1, 1, 3'b000, 1,  1, 0, 0, 3'b000, 8'd1));
    tbl.push_back(v(1, 0, 3'b010, 2,  1, 0, 0, 3'b000, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 1,  1, 0, 0, 3'b010, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 1,  1, 0, 0, 3'b010, 8'd1));
    tbl.push_back(v(1, 0, 3'b000, 1,  1, 0, 0, 3'b000, 8'd1));
    tbl.push_back(v(1, 0, 3'b100, 5,  1, 1, 1, 3'b100, 8'd2));
    tbl.push_back(v(0, 1, 3'b100, 2,  1, 1, 1, 3'b100, 8'd2));
    tbl.push_back(v(0, 1, 3'b100, 1,  0, 0, 0, 3'b000, 8'd2));

    drive(1'b0, 1'b0, 3'b000);
    model_reset();
    rst = 1'b1;
    step();
    step();
    check("reset_state", dut_pack(), 14'd0);
    #2 rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].turn, tbl[i].stop, tbl[i].pir);
      for (int k = 0; k < tbl[i].edges; k++) step();
      check($sformatf("vec%0d", i), dut_pack(),
            {tbl[i].armed, tbl[i].alarm, tbl[i].blink, tbl[i].zone, tbl[i].count});
    end

    // Asynchronous reset in the middle of an alarm
    drive(1'b1, 1'b0, 3'b001);
    wait_out("reach_alarm", 0, 1'b1, 20);
    step();
    step();
    #3 rst = 1'b1;
    #1 check("async_rst_mid_alarm", dut_pack(), 14'd0);
    model_reset();
    drive(1'b0, 1'b0, 3'b000);
    step();
    check("rst_held", dut_pack(), 14'd0);
    #2 rst = 1'b0;

    // 256 alarm entries: count must stop at 255
    drive(1'b1, 1'b0, 3'b000);
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 1'b0, 3'b001);
      wait_out("sat_alarm_on", 0, 1'b1, 20);
      drive(1'b0, 1'b0, 3'b000);
      wait_out("sat_disarm", 1, 1'b0, 10);
      drive(1'b1, 1'b0, 3'b000);
      wait_out("sat_rearm", 1, 1'b1, 10);
      if (i == 1 || i == 255 || i == 256)
        check($sformatf("sat_count_%0d", i), {6'd0, bus.alarm_count},
              {6'd0, (i > 255) ? 8'd255 : 8'(i)});
    end

    // Random stimulus against the model
    do_reset();
    begin
      logic       turn_r, stop_r;
      logic [2:0] pir_r;
      turn_r = 1'b1; stop_r = 1'b0; pir_r = 3'b000;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 99) < 3) turn_r = ~turn_r;
        if ($urandom_range(0, 99) < 15) stop_r = ~stop_r;
        if ($urandom_range(0, 99) < 20)
          pir_r = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        drive(turn_r, stop_r, pir_r);
        step();
        check("random_vs_model", dut_pack(), model_pack());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/motion_alarm_ctrl.md
# motion_alarm_ctrl

Motion-detection alarm controller: the device-under-test stage that consumes the arm switch, stop button and three PIR sensor lines produced by the bench stimulus block. It synchronises the asynchronous inputs and requires motion to persist before raising the alarm. It runs an arm/confirm/alarm state machine and reports which zones tripped plus a saturating event count. It sits between the raw sensor/switch inputs and the alarm/LED outputs.

## Interface
- CONFIRM_CYCLES, 3: consecutive synchronised cycles of motion required to raise alarm (legal 1..15).
- ALARM_MIN_CYCLES, 16: minimum cycles alarm stays asserted before stop_alarm is honoured (legal 1..255).
- BLINK_DIV, 4: led_blink half-period in cycles while alarmed (legal 1..255).
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- turn  in  1  arm switch: 1 = system on, 0 = system off; asynchronous.
- stop_alarm  in  1  operator stop, level; asynchronous.
- pir_sensor_1 / pir_sensor_2 / pir_sensor_3  in  1 each  PIR motion lines, level; asynchronous.
- armed  out  1  system armed (state ARMED, CONFIRM or ALARM).
- alarm  out  1  alarm asserted (state ALARM).
- led_blink  out  1  blinking indicator, active only in ALARM.
- zone  out  3  sticky zone mask {pir3,pir2,pir1} captured during CONFIRM/ALARM.
- alarm_count  out  8  number of alarm entries since reset, saturating.

## Operation
- All five async inputs pass through a 2-flop synchroniser; logic uses synchronised values only. motion = OR of synced PIRs.
- States: IDLE, ARMED, CONFIRM, ALARM. Registered outputs derived from state.
- Global priority each cycle: rst > synced turn==0 > everything else. turn==0 forces IDLE on the next edge from any state, clears zone, counters, led_blink.
- IDLE: turn==1 -> ARMED.
- ARMED: motion==1 -> CONFIRM, confirm counter = 1, zone |= synced PIRs. If CONFIRM_CYCLES==1 go straight to ALARM instead.
- CONFIRM: motion==1 and counter==CONFIRM_CYCLES-1 -> ALARM; motion==1 otherwise -> counter+1, zone |= PIRs; motion==0 -> ARMED, zone cleared, counter cleared. Different sensors may alternate; only the OR must stay high.
- ALARM entry: alarm_count += 1, saturating at 255 (never wraps); min-hold counter starts at 0; led_blink = 1.
- ALARM: zone keeps OR-ing new PIR activity. Min-hold counter increments, saturating at ALARM_MIN_CYCLES. Synced stop_alarm==1 and counter==ALARM_MIN_CYCLES -> ARMED, zone cleared, led_blink 0. stop_alarm before the minimum is ignored, not remembered; a held stop takes effect once the minimum is reached. Motion ending does not clear alarm.
- led_blink toggles every BLINK_DIV cycles in ALARM via a divider reset on ALARM entry.
- stop_alarm in IDLE/ARMED/CONFIRM has no effect.
- alarm_count is cleared only by rst; turn does not clear it.

## Timing
- Reset (async assert, any time incl. mid-alarm): state IDLE, synchronisers 0, armed=0, alarm=0, led_blink=0, zone=3'b000, alarm_count=0, all internal counters 0. Release is sampled synchronously; first transition is possible on the first edge after deassertion.
- Input-to-state latency: 2 edges (synchroniser). turn rising -> armed=1 after the 3rd rising edge.
- PIR held high from before edge E: CONFIRM entered at edge E+2; alarm=1 after edge E+1+CONFIRM_CYCLES (default: alarm high after the 5th edge counting E as 1st). A PIR pulse shorter than CONFIRM_CYCLES synced cycles never alarms.
- stop_alarm honoured: alarm falls 1 edge after the cycle where synced stop==1 and the minimum is met, i.e. earliest ALARM_MIN_CYCLES+1 edges after entry.
- turn falling: outputs clear 3 edges after the input change (2 sync + 1 transition).
- Simultaneous turn==0 and stop/motion: turn wins -> IDLE.
- Simultaneous stop and new motion in ALARM: go to ARMED; new motion re-enters CONFIRM on the following edge.

## Test plan
- Reset then turn=1, no PIR for 20 cycles -> armed=1 from edge 3, alarm=0, zone=000, alarm_count=0.
- Armed; pir_sensor_1 and pir_sensor_3 high for 5 cycles then low -> alarm=1 after 5th edge, zone=3'b101, alarm_count=1, alarm stays high after PIRs drop, led_blink toggles every 4 cycles.
- Armed; pir_sensor_2 high 2 cycles only -> CONFIRM then back to ARMED, alarm=0, zone=000, alarm_count=0.
- In ALARM, stop_alarm held from 5 cycles after entry -> alarm stays 1 until minimum 16 reached, then ARMED, zone=000, led_blink=0.
- In ALARM, turn=0 with stop_alarm=1 same cycle -> IDLE 3 edges later, armed=0, alarm_count unchanged.
- rst pulsed mid-ALARM between clock edges -> all outputs 0 immediately, alarm_count=0; 256 alarm cycles -> alarm_count saturates at 255.
